vec_cache_evict_buf: RTL and testbench
======================================

// Module: vec_cache_evict_buf
// PURPOSE
//  Evict data buffer (EVDB). Sits between the data-SRAM read pipeline and the downstream (DS) write port.
//  Collects DS_N 1024-bit evict beats per victim line into an allocated entry, in any arrival order.
//  Once a line is complete it is queued. Lines are sent to DS in completion order as DS_N valid/ready beats.
//  On the last accepted beat the entry is freed and evict completion is reported to the MSHR/ROB.
// PARAMETERS
//  ENTRY_NUM  EVDB_ENTRY_NUM (64)  number of line entries; power of 2
//  BEATS      DS_N (4)             beats per line (CACHE_LINE_SIZE/BUS_WIDTH)
//  ID_W       $clog2(ENTRY_NUM)    entry index width (= DB_ENTRY_IDX_WIDTH)
// PORTS
//  clk               in   1                      clock
//  rst               in   1                      async reset, active high
//  alloc_req         in   1                      evict arbiter requests an entry
//  alloc_gnt         out  1                      entry granted this cycle (combinational, alloc_req & any free)
//  alloc_id          out  ID_W                   granted entry = lowest-index FREE entry
//  wr_vld            in   1                      evict beat from RAM; no backpressure, always sampled
//  wr_pld            in   ram_to_evdb_pld_t      data + evict_req_pld (db_entry_id selects entry)
//  wr_beat           in   $clog2(BEATS)          beat number (req_num) of this write
//  ds_vld            out  1                      evict beat to DS valid
//  ds_rdy            in   1                      DS accepts beat
//  ds_pld            out  evict_to_ds_pld_t      beat data, addr, last, rob/db entry id, txn_id, sideband
//  done_vld          out  1                      1-cycle pulse: line fully accepted by DS
//  done_rob_entry_id out  MSHR_ENTRY_IDX_WIDTH   rob_entry_id of completed line
//  free_cnt          out  $clog2(ENTRY_NUM+1)    number of FREE entries
//  err               out  1                      sticky protocol-error flag
// BEHAVIOUR
//  Reset: all entries FREE, beat masks 0, send queue empty, ds_vld=0, done_vld=0, err=0, free_cnt=ENTRY_NUM.
//  Per-entry state: FREE -> ALLOC (on grant) -> FILL (first beat) -> QUEUED (mask all-ones) -> SENDING -> FREE.
//  Alloc: the grant takes effect at the clock edge. An entry freed in cycle N is not grantable until N+1.
//   No grant when free_cnt==0.
//  Write: beat data is stored at [db_entry_id][wr_beat] and the mask bit is set.
//   The header (addr, txn_id, sideband, rob_entry_id, db_entry_id) is captured from the first beat.
//   Write to a FREE/QUEUED/SENDING entry: data dropped, err set.
//   Repeat beat in FILL: data overwritten, mask unchanged, err set.
//  Completion: the write that makes the mask all-ones in cycle N pushes the id into the send FIFO (depth ENTRY_NUM).
//   At most one push per cycle. The FIFO cannot overflow because it is bounded by the entry count.
//  Send FSM IDLE/SEND:
//   IDLE & FIFO non-empty -> SEND with beat=0; ds_vld is high the next cycle.
//   Minimum latency is completing write at edge N -> ds_vld at N+1.
//   In SEND, ds_vld=1 holds a stable pld until ds_rdy; each handshake increments beat.
//   ds_pld.last = (beat==BEATS-1).
//   ds_pld.addr = captured tag/index; offset = beat*(BUS_WIDTH/8), zero-extended.
//   Last handshake: pop FIFO, free the entry, pulse done_vld with its rob_entry_id, then:
//    if FIFO has another id, stay in SEND with beat=0 (back-to-back; no bubble);
//    else go to IDLE.
//  Simultaneous events: alloc, write and send-free may all occur in one cycle.
//   free_cnt = prev - gnt + free.
//   A write to the entry being freed that cycle is an error (dropped).
//  Beats of different entries may interleave freely on wr_*; DS order = line completion order.
//  Reset mid-operation: all state is cleared asynchronously; any partially sent line is abandoned and no done_vld is issued.
// TESTING
//  1 alloc x1 -> id 0; write beats 0..3 of entry 0 with data 0xA0..0xA3, ds_rdy=1
//    -> 4 beats (offsets 0,128,256,384), last on beat 3, done_vld with rob id.
//  2 beats in order 3,1,0,2 -> no ds_vld before the 4th write; DS data still ordered beat 0..3.
//  3 fill entries 5 then 2, completing 2 first -> DS sends entry 2 then 5 back-to-back with no idle cycle.
//  4 ds_rdy toggles 1010 -> each beat held stable while rdy=0; exactly 4 handshakes, single done pulse.
//  5 allocate 64 -> free_cnt=0, alloc_gnt=0 for request 65.
//    Free entry 7 at cycle N: it is not granted at N and is granted at N+1.
//  6 write to FREE entry 9 or repeat beat 1 -> err=1 sticky, mask/send unaffected.
//    Assert rst mid-SEND -> ds_vld=0 immediately, free_cnt=64.

Source files
------------

// File: rtl/vec_cache_evict_buf_if.sv
// Evict buffer bus: allocation, RAM beat writes, downstream beats and completion.
interface vec_cache_evict_buf_if #(
  parameter int ID_W   = 6,
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 40,
  parameter int ROB_W  = 6,
  parameter int TXN_W  = 8,
  parameter int SB_W   = 4,
  parameter int BEAT_W = 2
);
  logic              alloc_req;
  logic              alloc_gnt;
  logic [ID_W-1:0]   alloc_id;

  logic              wr_vld;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [TXN_W-1:0]  wr_txn_id;
  logic [SB_W-1:0]   wr_sideband;
  logic [ROB_W-1:0]  wr_rob_entry_id;
  logic [ID_W-1:0]   wr_db_entry_id;
  logic [BEAT_W-1:0] wr_beat;

  logic              ds_vld;
  logic              ds_rdy;
  logic [DATA_W-1:0] ds_data;
  logic [ADDR_W-1:0] ds_addr;
  logic              ds_last;
  logic [ROB_W-1:0]  ds_rob_entry_id;
  logic [ID_W-1:0]   ds_db_entry_id;
  logic [TXN_W-1:0]  ds_txn_id;
  logic [SB_W-1:0]   ds_sideband;

  logic              done_vld;
  logic [ROB_W-1:0]  done_rob_entry_id;

  modport slave (
    input  alloc_req, wr_vld, wr_data, wr_addr, wr_txn_id, wr_sideband,
           wr_rob_entry_id, wr_db_entry_id, wr_beat, ds_rdy,
    output alloc_gnt, alloc_id, ds_vld, ds_data, ds_addr, ds_last,
           ds_rob_entry_id, ds_db_entry_id, ds_txn_id, ds_sideband,
           done_vld, done_rob_entry_id
  );

  modport master (
    output alloc_req, wr_vld, wr_data, wr_addr, wr_txn_id, wr_sideband,
           wr_rob_entry_id, wr_db_entry_id, wr_beat, ds_rdy,
    input  alloc_gnt, alloc_id, ds_vld, ds_data, ds_addr, ds_last,
           ds_rob_entry_id, ds_db_entry_id, ds_txn_id, ds_sideband,
           done_vld, done_rob_entry_id
  );
endinterface

// File: rtl/vec_cache_evict_buf.sv
// Evict data buffer: gathers out-of-order evict beats per victim line, queues
// completed lines in completion order and streams them to the downstream port.
module vec_cache_evict_buf #(
  parameter int ENTRY_NUM = 64,
  parameter int BEATS     = 4,
  parameter int ID_W      = $clog2(ENTRY_NUM),
  parameter int DATA_W    = 1024,
  parameter int ADDR_W    = 40,
  parameter int ROB_W     = 6,
  parameter int TXN_W     = 8,
  parameter int SB_W      = 4,
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int CNT_W    = $clog2(ENTRY_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  vec_cache_evict_buf_if.slave bus,
  output logic [CNT_W-1:0]  free_cnt_o,
  output logic              err_o
);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int OFF_W   = $clog2(BEATS * (DATA_W / 8));
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {E_FREE, E_ALLOC, E_FILL, E_QUEUED, E_SENDING} ent_st_e;
  typedef enum logic {S_IDLE, S_SEND} snd_st_e;

  ent_st_e           st_q    [ENTRY_NUM];
  logic [BEATS-1:0]  mask_q  [ENTRY_NUM];
  logic [DATA_W-1:0] data_q  [ENTRY_NUM][BEATS];
  logic [ADDR_W-1:0] addr_q  [ENTRY_NUM];
  logic [TXN_W-1:0]  txn_q   [ENTRY_NUM];
  logic [SB_W-1:0]   sb_q    [ENTRY_NUM];
  logic [ROB_W-1:0]  rob_q   [ENTRY_NUM];
  logic [ID_W-1:0]   fifo_q  [ENTRY_NUM];
  logic [ID_W:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  free_cnt_q;
  logic              err_q;
  logic              done_vld_q;
  logic [ROB_W-1:0]  done_rob_q;
  snd_st_e           snd_st_q, snd_st_d;
  logic [BEAT_W-1:0] beat_q;

  logic              any_free, gnt;
  logic [ID_W-1:0]   alloc_idx;
  ent_st_e           wr_st;
  logic [BEATS-1:0]  wr_mask, beat_bit, new_mask;
  logic              wr_fill, wr_err, push;
  logic [ID_W-1:0]   head;
  logic [ID_W:0]     fifo_cnt;
  logic              fifo_empty;
  logic              ds_vld, hs, last, pop;

  // Lowest-index free entry is offered for allocation
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (st_q[i] == E_FREE) begin
        any_free  = 1'b1;
        alloc_idx = ID_W'(i);
      end
    end
  end

  assign gnt           = bus.alloc_req & any_free;
  assign bus.alloc_gnt = gnt;
  assign bus.alloc_id  = alloc_idx;

  // Classify the incoming beat: legal fill, protocol error, line completion
  always_comb begin
    wr_st    = st_q[bus.wr_db_entry_id];
    wr_mask  = mask_q[bus.wr_db_entry_id];
    beat_bit = BEATS'(1) << bus.wr_beat;
    new_mask = wr_mask | beat_bit;
    wr_fill  = bus.wr_vld & ((wr_st == E_ALLOC) | (wr_st == E_FILL));
    wr_err   = bus.wr_vld & (~((wr_st == E_ALLOC) | (wr_st == E_FILL)) |
                             ((wr_mask & beat_bit) != '0));
    push     = wr_fill & (&new_mask);
  end

  assign head       = fifo_q[rd_ptr_q[ID_W-1:0]];
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  // Send FSM state register and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_st_q <= S_IDLE;
      beat_q   <= '0;
    end else begin
      snd_st_q <= snd_st_d;
      if (hs) beat_q <= last ? '0 : beat_q + 1'b1;
    end
  end

  // Send FSM next state; a pending or same-cycle completion keeps SEND without a bubble
  always_comb begin
    snd_st_d = snd_st_q;
    case (snd_st_q)
      S_IDLE:  if (!fifo_empty) snd_st_d = S_SEND;
      S_SEND:  if (pop && !((fifo_cnt > (ID_W+1)'(1)) || push)) snd_st_d = S_IDLE;
      default: snd_st_d = S_IDLE;
    endcase
  end

  // Send FSM outputs
  always_comb begin
    ds_vld = (snd_st_q == S_SEND);
    last   = (beat_q == BEAT_W'(BEATS - 1));
    hs     = ds_vld & bus.ds_rdy;
    pop    = hs & last;
  end

  assign bus.ds_vld          = ds_vld;
  assign bus.ds_data         = data_q[head][beat_q];
  assign bus.ds_addr         = (addr_q[head] & ~OFF_MASK) | (ADDR_W'(beat_q) << BYTE_SH);
  assign bus.ds_last         = last;
  assign bus.ds_rob_entry_id = rob_q[head];
  assign bus.ds_db_entry_id  = head;
  assign bus.ds_txn_id       = txn_q[head];
  assign bus.ds_sideband     = sb_q[head];
  assign bus.done_vld        = done_vld_q;
  assign bus.done_rob_entry_id = done_rob_q;
  assign free_cnt_o          = free_cnt_q;
  assign err_o               = err_q;

  // Entry lifecycle, send-queue pointers, free count and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        st_q[i]   <= E_FREE;
        mask_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      free_cnt_q <= CNT_W'(ENTRY_NUM);
      err_q      <= 1'b0;
      done_vld_q <= 1'b0;
    end else begin
      if (gnt) st_q[alloc_idx] <= E_ALLOC;
      if (wr_fill) begin
        mask_q[bus.wr_db_entry_id] <= new_mask;
        st_q[bus.wr_db_entry_id]   <= push ? E_QUEUED : E_FILL;
      end
      if (ds_vld && (st_q[head] == E_QUEUED)) st_q[head] <= E_SENDING;
      if (pop) begin
        st_q[head]   <= E_FREE;
        mask_q[head] <= '0;
        rd_ptr_q     <= rd_ptr_q + 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (wr_err) err_q <= 1'b1;
      free_cnt_q <= free_cnt_q - CNT_W'(gnt) + CNT_W'(pop);
      done_vld_q <= pop;
    end
  end

  // Beat data, line header from the first beat, queued ids, completion rob id
  always_ff @(posedge clk) begin
    if (wr_fill) begin
      data_q[bus.wr_db_entry_id][bus.wr_beat] <= bus.wr_data;
      if (wr_st == E_ALLOC) begin
        addr_q[bus.wr_db_entry_id] <= bus.wr_addr;
        txn_q[bus.wr_db_entry_id]  <= bus.wr_txn_id;
        sb_q[bus.wr_db_entry_id]   <= bus.wr_sideband;
        rob_q[bus.wr_db_entry_id]  <= bus.wr_rob_entry_id;
      end
    end
    if (push) fifo_q[wr_ptr_q[ID_W-1:0]] <= bus.wr_db_entry_id;
    if (pop) done_rob_q <= rob_q[head];
  end
endmodule

// File: tb/tb_vec_cache_evict_buf.sv
// Directed bench for the evict data buffer.
module tb_vec_cache_evict_buf;
  localparam int DW = 1024;
  localparam int AW = 40;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] free_cnt;
  logic err;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] cur_txn;

  always #5 clk = ~clk;

  vec_cache_evict_buf_if bus();

  vec_cache_evict_buf dut (
    .clk(clk), .rst(rst), .bus(bus), .free_cnt_o(free_cnt), .err_o(err)
  );

  // Downstream monitor
  logic [DW-1:0] hs_data[$];
  logic [AW-1:0] hs_addr[$];
  logic          hs_last[$];
  logic [5:0]    hs_db[$];
  logic [7:0]    hs_txn[$];
  int            hs_cyc[$];
  logic [5:0]    done_rob[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ds_vld && bus.ds_rdy) begin
        hs_data.push_back(bus.ds_data);
        hs_addr.push_back(bus.ds_addr);
        hs_last.push_back(bus.ds_last);
        hs_db.push_back(bus.ds_db_entry_id);
        hs_txn.push_back(bus.ds_txn_id);
        hs_cyc.push_back(cyc);
      end
      if (bus.done_vld) done_rob.push_back(bus.done_rob_entry_id);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    hs_data.delete(); hs_addr.delete(); hs_last.delete(); hs_db.delete();
    hs_txn.delete(); hs_cyc.delete(); done_rob.delete();
  endtask

  task automatic do_alloc(output logic g, output logic [5:0] id);
    bus.alloc_req = 1'b1;
    #1;
    g  = bus.alloc_gnt;
    id = bus.alloc_id;
    tick();
    bus.alloc_req = 1'b0;
  endtask

  task automatic do_wr(input logic [5:0] id, input logic [1:0] beat,
                       input logic [DW-1:0] data, input logic [AW-1:0] addr,
                       input logic [5:0] rob);
    bus.wr_vld          = 1'b1;
    bus.wr_db_entry_id  = id;
    bus.wr_beat         = beat;
    bus.wr_data         = data;
    bus.wr_addr         = addr;
    bus.wr_rob_entry_id = rob;
    bus.wr_txn_id       = cur_txn;
    bus.wr_sideband     = 4'h3;
    tick();
    bus.wr_vld = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int k = 0; k < budget && done_rob.size() < n; k++) tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr_mon();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alloc_req = 0; bus.wr_vld = 0; bus.ds_rdy = 0; bus.wr_data = '0;
    bus.wr_addr = '0; bus.wr_txn_id = '0; bus.wr_sideband = '0;
    bus.wr_rob_entry_id = '0; bus.wr_db_entry_id = '0; bus.wr_beat = '0;
    cur_txn = 8'h00;
    tick(); tick();
    n_tests++; if (bus.ds_vld !== 1'b0) begin n_fail++; $display("FAIL reset_ds_vld got %0b exp 0", bus.ds_vld); end
    n_tests++; if (bus.done_vld !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", bus.done_vld); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", err); end
    n_tests++; if (free_cnt !== 7'd64) begin n_fail++; $display("FAIL reset_free_cnt got %0d exp 64", free_cnt); end
    n_tests++; if (bus.alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %0b exp 0", bus.alloc_gnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic g; logic [5:0] id;
    clr_mon();
    bus.ds_rdy = 1'b1;
    do_alloc(g, id);
    n_tests++; if (g !== 1'b1 || id !== 6'd0) begin n_fail++; $display("FAIL basic_alloc got gnt=%0b id=%0d exp gnt=1 id=0", g, id); end
    n_tests++; if (free_cnt !== 7'd63) begin n_fail++; $display("FAIL basic_free_after_alloc got %0d exp 63", free_cnt); end
    cur_txn = 8'h5A;
    do_wr(6'd0, 2'd0, DW'(32'hA0), 40'h1234, 6'd5);
    cur_txn = 8'hFF;
    do_wr(6'd0, 2'd1, DW'(32'hA1), 40'hFFFF, 6'd9);
    do_wr(6'd0, 2'd2, DW'(32'hA2), 40'hFFFF, 6'd9);
    do_wr(6'd0, 2'd3, DW'(32'hA3), 40'hFFFF, 6'd9);
    tick();
    n_tests++; if (bus.ds_vld !== 1'b1) begin n_fail++; $display("FAIL basic_latency ds_vld got %0b exp 1", bus.ds_vld); end
    wait_done(1, 20);
    tick(); tick();
    n_tests++; if (hs_data.size() != 4 || done_rob.size() != 1) begin
      n_fail++; $display("FAIL basic_counts got hs=%0d done=%0d exp hs=4 done=1", hs_data.size(), done_rob.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++; if (hs_data[i] !== DW'(32'hA0 + i)) begin n_fail++; $display("FAIL basic_data[%0d] got %0h exp %0h", i, hs_data[i], 32'hA0 + i); end
        n_tests++; if (hs_addr[i] !== AW'(40'h1200 + 40'h80 * i)) begin n_fail++; $display("FAIL basic_addr[%0d] got %0h exp %0h", i, hs_addr[i], 40'h1200 + 40'h80 * i); end
        n_tests++; if (hs_last[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d] got %0b exp %0b", i, hs_last[i], (i == 3)); end
        n_tests++; if (hs_txn[i] !== 8'h5A || hs_db[i] !== 6'd0) begin n_fail++; $display("FAIL basic_hdr[%0d] got txn=%0h db=%0d exp txn=5a db=0", i, hs_txn[i], hs_db[i]); end
      end
      n_tests++; if (done_rob[0] !== 6'd5) begin n_fail++; $display("FAIL basic_done_rob got %0d exp 5", done_rob[0]); end
    end
    n_tests++; if (free_cnt !== 7'd64) begin n_fail++; $display("FAIL basic_free_end got %0d exp 64", free_cnt); end
  endtask

  task automatic test_out_of_order();
    logic g; logic [5:0] id;
    logic [1:0] order [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    clr_mon();
    bus.ds_rdy = 1'b1;
    do_alloc(g, id);
    n_tests++; if (g !== 1'b1 || id !== 6'd0) begin n_fail++; $display("FAIL ooo_alloc got gnt=%0b id=%0d exp gnt=1 id=0", g, id); end
    for (int k = 0; k < 4; k++) begin
      do_wr(6'd0, order[k], DW'(32'hB0 + order[k]), 40'h4000, 6'd7);
      if (k < 3) begin
        n_tests++; if (bus.ds_vld !== 1'b0) begin n_fail++; $display("FAIL ooo_early_vld after write %0d got %0b exp 0", k, bus.ds_vld); end
      end
    end
    wait_done(1, 20);
    n_tests++; if (hs_data.size() != 4) begin
      n_fail++; $display("FAIL ooo_count got %0d exp 4", hs_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++; if (hs_data[i] !== DW'(32'hB0 + i)) begin n_fail++; $display("FAIL ooo_data[%0d] got %0h exp %0h", i, hs_data[i], 32'hB0 + i); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic g; logic [5:0] id;
    clr_mon();
    bus.ds_rdy = 1'b0;
    for (int k = 0; k < 6; k++) do_alloc(g, id);
    n_tests++; if (id !== 6'd5) begin n_fail++; $display("FAIL b2b_alloc_last got %0d exp 5", id); end
    for (int b = 0; b < 3; b++) do_wr(6'd5, 2'(b), DW'(32'h50 + b), 40'h5000, 6'd15);
    for (int b = 0; b < 4; b++) do_wr(6'd2, 2'(b), DW'(32'h20 + b), 40'h2000, 6'd12);
    do_wr(6'd5, 2'd3, DW'(32'h53), 40'h5000, 6'd15);
    tick();
    bus.ds_rdy = 1'b1;
    wait_done(2, 40);
    n_tests++; if (hs_data.size() != 8 || done_rob.size() != 2) begin
      n_fail++; $display("FAIL b2b_counts got hs=%0d done=%0d exp hs=8 done=2", hs_data.size(), done_rob.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++; if (hs_db[i] !== ((i < 4) ? 6'd2 : 6'd5) || hs_data[i] !== DW'((i < 4) ? 32'h20 + i : 32'h50 + i - 4)) begin
          n_fail++; $display("FAIL b2b_order[%0d] got db=%0d data=%0h", i, hs_db[i], hs_data[i]);
        end
        n_tests++; if (hs_cyc[i] != hs_cyc[0] + i) begin n_fail++; $display("FAIL b2b_gap[%0d] got cycle %0d exp %0d", i, hs_cyc[i], hs_cyc[0] + i); end
      end
      n_tests++; if (done_rob[0] !== 6'd12 || done_rob[1] !== 6'd15) begin
        n_fail++; $display("FAIL b2b_done got %0d,%0d exp 12,15", done_rob[0], done_rob[1]);
      end
    end
    tick();
    n_tests++; if (free_cnt !== 7'd60) begin n_fail++; $display("FAIL b2b_free got %0d exp 60", free_cnt); end
  endtask

  task automatic test_rdy_toggle();
    logic g; logic [5:0] id;
    int hs = 0;
    clr_mon();
    bus.ds_rdy = 1'b0;
    do_alloc(g, id);
    n_tests++; if (id !== 6'd2) begin n_fail++; $display("FAIL tog_alloc got %0d exp 2", id); end
    for (int b = 0; b < 4; b++) do_wr(6'd2, 2'(b), DW'(32'hC0 + b), 40'h8000, 6'd22);
    for (int k = 0; k < 10 && !bus.ds_vld; k++) tick();
    for (int k = 0; k < 16 && hs < 4; k++) begin
      bus.ds_rdy = ~k[0];
      #1;
      n_tests++; if (bus.ds_vld !== 1'b1 || bus.ds_data !== DW'(32'hC0 + hs) || bus.ds_last !== (hs == 3)) begin
        n_fail++; $display("FAIL tog_beat cycle %0d got vld=%0b data=%0h last=%0b exp data=%0h", k, bus.ds_vld, bus.ds_data, bus.ds_last, 32'hC0 + hs);
      end
      if (bus.ds_vld && bus.ds_rdy) hs++;
      tick();
    end
    bus.ds_rdy = 1'b0;
    tick(); tick();
    n_tests++; if (hs_data.size() != 4) begin n_fail++; $display("FAIL tog_handshakes got %0d exp 4", hs_data.size()); end
    n_tests++; if (done_rob.size() != 1) begin n_fail++; $display("FAIL tog_done_count got %0d exp 1", done_rob.size()); end
    else begin
      n_tests++; if (done_rob[0] !== 6'd22) begin n_fail++; $display("FAIL tog_done_rob got %0d exp 22", done_rob[0]); end
    end
  endtask

  task automatic test_full();
    logic [5:0] exp_id;
    logic found = 1'b0;
    clr_mon();
    bus.ds_rdy = 1'b0;
    bus.alloc_req = 1'b1;
    for (int k = 0; k < 60; k++) begin
      exp_id = (k == 0) ? 6'd2 : 6'(k + 4);
      #1;
      n_tests++; if (bus.alloc_gnt !== 1'b1 || bus.alloc_id !== exp_id) begin
        n_fail++; $display("FAIL full_alloc[%0d] got gnt=%0b id=%0d exp gnt=1 id=%0d", k, bus.alloc_gnt, bus.alloc_id, exp_id);
      end
      tick();
    end
    n_tests++; if (free_cnt !== 7'd0) begin n_fail++; $display("FAIL full_free_cnt got %0d exp 0", free_cnt); end
    #1;
    n_tests++; if (bus.alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL full_gnt65 got %0b exp 0", bus.alloc_gnt); end
    tick();
    for (int b = 0; b < 4; b++) do_wr(6'd7, 2'(b), DW'(32'h70 + b), 40'h7000, 6'd27);
    for (int k = 0; k < 10 && !bus.ds_vld; k++) tick();
    bus.ds_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.ds_vld && bus.ds_last) begin
        n_tests++; if (bus.alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL full_gnt_same_cycle got %0b exp 0", bus.alloc_gnt); end
        tick();
        #1;
        n_tests++; if (bus.alloc_gnt !== 1'b1 || bus.alloc_id !== 6'd7) begin
          n_fail++; $display("FAIL full_gnt_next got gnt=%0b id=%0d exp gnt=1 id=7", bus.alloc_gnt, bus.alloc_id);
        end
        tick();
        found = 1'b1;
        break;
      end
      tick();
    end
    bus.alloc_req = 1'b0;
    bus.ds_rdy = 1'b0;
    n_tests++; if (!found) begin n_fail++; $display("FAIL full_last_beat got timeout exp last beat"); end
    n_tests++; if (free_cnt !== 7'd0) begin n_fail++; $display("FAIL full_free_after_regrant got %0d exp 0", free_cnt); end
  endtask

  task automatic test_errors();
    logic g; logic [5:0] id;
    pulse_rst();
    bus.ds_rdy = 1'b1;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %0b exp 0", err); end
    do_wr(6'd9, 2'd0, DW'(32'h99), 40'h9000, 6'd1);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_free_write got %0b exp 1", err); end
    tick(); tick(); tick();
    n_tests++; if (err !== 1'b1 || bus.ds_vld !== 1'b0 || free_cnt !== 7'd64) begin
      n_fail++; $display("FAIL err_free_sticky got err=%0b vld=%0b free=%0d exp 1 0 64", err, bus.ds_vld, free_cnt);
    end
    pulse_rst();
    bus.ds_rdy = 1'b1;
    do_alloc(g, id);
    do_wr(6'd0, 2'd1, DW'(32'hD1), 40'h3000, 6'd3);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_first_beat got %0b exp 0", err); end
    do_wr(6'd0, 2'd1, DW'(32'hE1), 40'h3000, 6'd3);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_repeat got %0b exp 1", err); end
    do_wr(6'd0, 2'd0, DW'(32'hE0), 40'h3000, 6'd3);
    do_wr(6'd0, 2'd2, DW'(32'hE2), 40'h3000, 6'd3);
    tick(); tick();
    n_tests++; if (bus.ds_vld !== 1'b0 || hs_data.size() != 0) begin
      n_fail++; $display("FAIL err_mask_unchanged got vld=%0b hs=%0d exp 0 0", bus.ds_vld, hs_data.size());
    end
    do_wr(6'd0, 2'd3, DW'(32'hE3), 40'h3000, 6'd3);
    wait_done(1, 20);
    n_tests++; if (hs_data.size() != 4) begin n_fail++; $display("FAIL err_line_count got %0d exp 4", hs_data.size()); end
    else begin
      n_tests++; if (hs_data[1] !== DW'(32'hE1)) begin n_fail++; $display("FAIL err_overwrite got %0h exp e1", hs_data[1]); end
    end
  endtask

  task automatic test_reset_mid_send();
    logic g; logic [5:0] id;
    pulse_rst();
    bus.ds_rdy = 1'b0;
    do_alloc(g, id);
    for (int b = 0; b < 4; b++) do_wr(6'd0, 2'(b), DW'(32'hF0 + b), 40'h6000, 6'd30);
    for (int k = 0; k < 10 && !bus.ds_vld; k++) tick();
    n_tests++; if (bus.ds_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_vld_before got %0b exp 1", bus.ds_vld); end
    bus.ds_rdy = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (bus.ds_vld !== 1'b0 || free_cnt !== 7'd64 || bus.done_vld !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got vld=%0b free=%0d done=%0b exp 0 64 0", bus.ds_vld, free_cnt, bus.done_vld);
    end
    bus.ds_rdy = 1'b0;
    tick();
    rst = 1'b0;
    bus.ds_rdy = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    n_tests++; if (done_rob.size() != 0 || bus.ds_vld !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_done got done=%0d vld=%0b exp 0 0", done_rob.size(), bus.ds_vld);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_order();
    test_back_to_back();
    test_rdy_toggle();
    test_full();
    test_errors();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
